// File: rtl/axi_scratch_slave.sv
// Single-beat AXI4 slave backed by a flop-array scratch memory.
// AW and W are held independently, joined at commit; reads are serviced concurrently.
module axi_scratch_slave #(
  parameter int                        AXI_ID_WIDTH   = 10,
  parameter int                        AXI_ADDR_WIDTH = 64,
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 64'h9000_0000,
  parameter int                        DEPTH          = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  output logic                        b_valid_o,
  input  logic                        b_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]                  b_resp_o,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  output logic                        r_valid_o,
  input  logic                        r_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o,
  output logic [31:0]                 wr_count_o
);

  localparam int WORD_BYTES = AXI_DATA_WIDTH / 8;
  localparam int IDX_W      = $clog2(DEPTH);
  localparam int OFS        = $clog2(WORD_BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] END_ADDR =
    BASE_ADDR + AXI_ADDR_WIDTH'(DEPTH * WORD_BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [AXI_DATA_WIDTH-1:0] word_t;

  function automatic logic dec_err(input logic [AXI_ADDR_WIDTH-1:0] addr, input logic [7:0] len);
    return (addr < BASE_ADDR) || (addr >= END_ADDR) || (len != 8'd0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> OFS);
  endfunction

  logic                        aw_full_q, aw_full_d;
  logic [AXI_ID_WIDTH-1:0]     aw_id_q,   aw_id_d;
  logic [IDX_W-1:0]            aw_idx_q,  aw_idx_d;
  logic                        aw_err_q,  aw_err_d;
  logic                        w_full_q,  w_full_d;
  word_t                       w_data_q,  w_data_d;
  logic [WORD_BYTES-1:0]       w_strb_q,  w_strb_d;
  logic                        b_valid_q, b_valid_d;
  logic [AXI_ID_WIDTH-1:0]     b_id_q,    b_id_d;
  logic [1:0]                  b_resp_q,  b_resp_d;
  logic                        r_valid_q, r_valid_d;
  logic [AXI_ID_WIDTH-1:0]     r_id_q,    r_id_d;
  word_t                       r_data_q,  r_data_d;
  logic [1:0]                  r_resp_q,  r_resp_d;
  logic [31:0]                 wr_count_q, wr_count_d;
  word_t                       mem_q [DEPTH];
  word_t                       mem_d [DEPTH];

  logic aw_hs, w_hs, ar_hs, commit, ar_err;

  assign aw_ready_o = !aw_full_q;
  assign w_ready_o  = !w_full_q;
  assign ar_ready_o = !r_valid_q || r_ready_i;

  // NOTE: every _d gets its default (hold) first, so no path through this block can infer a latch.
  always_comb begin
    aw_hs  = aw_valid_i && aw_ready_o;
    w_hs   = w_valid_i && w_ready_o;
    ar_hs  = ar_valid_i && ar_ready_o;
    commit = aw_full_q && w_full_q && !b_valid_q;
    ar_err = dec_err(ar_addr_i, ar_len_i);

    aw_full_d  = aw_full_q;  aw_id_d  = aw_id_q;  aw_idx_d = aw_idx_q; aw_err_d = aw_err_q;
    w_full_d   = w_full_q;   w_data_d = w_data_q; w_strb_d = w_strb_q;
    b_valid_d  = b_valid_q;  b_id_d   = b_id_q;   b_resp_d = b_resp_q;
    r_valid_d  = r_valid_q;  r_id_d   = r_id_q;   r_data_d = r_data_q; r_resp_d = r_resp_q;
    wr_count_d = wr_count_q;
    mem_d      = mem_q;

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      b_valid_d = 1'b1;
      b_id_d    = aw_id_q;
      b_resp_d  = aw_err_q ? RESP_SLVERR : RESP_OKAY;
      if (!aw_err_q) begin
        wr_count_d = wr_count_q + 32'd1;
        for (int b = 0; b < WORD_BYTES; b++) begin
          if (w_strb_q[b]) mem_d[aw_idx_q][8*b +: 8] = w_data_q[8*b +: 8];
        end
      end
    end else if (b_valid_q && b_ready_i) begin
      b_valid_d = 1'b0;
    end

    // Holding regs are empty whenever their handshake fires, so this never races commit.
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_id_d   = aw_id_i;
      aw_idx_d  = addr_idx(aw_addr_i);
      aw_err_d  = dec_err(aw_addr_i, aw_len_i);
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = w_data_i;
      w_strb_d = w_strb_i;
    end

    // Reads sample mem_q, so a same-edge commit to the same word returns the old data.
    if (ar_hs) begin
      r_valid_d = 1'b1;
      r_id_d    = ar_id_i;
      r_resp_d  = ar_err ? RESP_SLVERR : RESP_OKAY;
      r_data_d  = ar_err ? '0 : mem_q[addr_idx(ar_addr_i)];
    end else if (r_valid_q && r_ready_i) begin
      r_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_full_q  <= 1'b0; aw_id_q  <= '0; aw_idx_q <= '0; aw_err_q <= 1'b0;
      w_full_q   <= 1'b0; w_data_q <= '0; w_strb_q <= '0;
      b_valid_q  <= 1'b0; b_id_q   <= '0; b_resp_q <= '0;
      r_valid_q  <= 1'b0; r_id_q   <= '0; r_data_q <= '0; r_resp_q <= '0;
      wr_count_q <= '0;
      // NOTE: the scratch array is flops, not SRAM, so it is cleared by reset like any other state.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      aw_full_q  <= aw_full_d; aw_id_q  <= aw_id_d;  aw_idx_q <= aw_idx_d; aw_err_q <= aw_err_d;
      w_full_q   <= w_full_d;  w_data_q <= w_data_d; w_strb_q <= w_strb_d;
      b_valid_q  <= b_valid_d; b_id_q   <= b_id_d;   b_resp_q <= b_resp_d;
      r_valid_q  <= r_valid_d; r_id_q   <= r_id_d;   r_data_q <= r_data_d; r_resp_q <= r_resp_d;
      wr_count_q <= wr_count_d;
      mem_q      <= mem_d;
    end
  end

  assign b_valid_o  = b_valid_q;
  assign b_id_o     = b_id_q;
  assign b_resp_o   = b_resp_q;
  assign r_valid_o  = r_valid_q;
  assign r_id_o     = r_id_q;
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;
  assign r_last_o   = r_valid_q;
  assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_axi_scratch_slave.sv
// Self-checking bench for axi_scratch_slave: directed scenarios plus randomized
// single-beat traffic against a word-array reference model.
module tb_axi_scratch_slave;

  localparam int          IDW   = 10;
  localparam int          AW    = 64;
  localparam int          DW    = 64;
  localparam int          DEPTH = 64;
  localparam logic [63:0] BASE  = 64'h9000_0000;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            aw_valid_i = 0, aw_ready_o;
  logic [IDW-1:0]  aw_id_i = '0;
  logic [AW-1:0]   aw_addr_i = '0;
  logic [7:0]      aw_len_i = '0;
  logic            w_valid_i = 0, w_ready_o;
  logic [DW-1:0]   w_data_i = '0;
  logic [DW/8-1:0] w_strb_i = '0;
  logic            b_valid_o, b_ready_i = 0;
  logic [IDW-1:0]  b_id_o;
  logic [1:0]      b_resp_o;
  logic            ar_valid_i = 0, ar_ready_o;
  logic [IDW-1:0]  ar_id_i = '0;
  logic [AW-1:0]   ar_addr_i = '0;
  logic [7:0]      ar_len_i = '0;
  logic            r_valid_o, r_ready_i = 0;
  logic [IDW-1:0]  r_id_o;
  logic [DW-1:0]   r_data_o;
  logic [1:0]      r_resp_o;
  logic            r_last_o;
  logic [31:0]     wr_count_o;

  axi_scratch_slave #(
    .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .BASE_ADDR(BASE), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o), .wr_count_o(wr_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] model_mem [DEPTH];
  logic [31:0] model_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit model_err(input logic [63:0] addr, input logic [7:0] len);
    return !(addr >= BASE && addr < BASE + 64'(DEPTH * 8)) || len != 0;
  endfunction

  function automatic int model_idx(input logic [63:0] addr);
    return int'((addr - BASE) / 8);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_cnt = 0;
  endtask

  task automatic model_write(input logic [63:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, input logic [7:0] len,
                             output logic [1:0] resp);
    if (model_err(addr, len)) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      for (int b = 0; b < 8; b++)
        if (strb[b]) model_mem[model_idx(addr)][8*b +: 8] = data[8*b +: 8];
      model_cnt++;
    end
  endtask

  function automatic logic [63:0] model_read(input logic [63:0] addr, input logic [7:0] len);
    return model_err(addr, len) ? 64'd0 : model_mem[model_idx(addr)];
  endfunction

  task automatic wait_ready_w();
    for (int i = 0; i < 20 && !(aw_ready_o && w_ready_o); i++) tick();
    check("wr_ready_timeout", aw_ready_o && w_ready_o, 1);
  endtask

  task automatic wait_ready_r();
    for (int i = 0; i < 20 && !ar_ready_o; i++) tick();
    check("ar_ready_timeout", ar_ready_o, 1);
  endtask

  task automatic drive_aw(input logic [63:0] addr, input logic [7:0] len, input logic [IDW-1:0] id);
    aw_valid_i = 1; aw_addr_i = addr; aw_len_i = len; aw_id_i = id;
  endtask

  task automatic drive_w(input logic [63:0] data, input logic [7:0] strb);
    w_valid_i = 1; w_data_i = data; w_strb_i = strb;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input logic [7:0] len, input logic [IDW-1:0] id);
    logic [1:0] resp;
    wait_ready_w();
    drive_aw(addr, len, id);
    drive_w(data, strb);
    tick();
    aw_valid_i = 0; w_valid_i = 0;
    model_write(addr, data, strb, len, resp);
    check("b_valid_early", b_valid_o, 0);
    tick();
    check("b_valid", b_valid_o, 1);
    check("b_id", b_id_o, id);
    check("b_resp", b_resp_o, resp);
    check("wr_count", wr_count_o, model_cnt);
    b_ready_i = 1;
    tick();
    b_ready_i = 0;
    check("b_valid_clear", b_valid_o, 0);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] len,
                         input logic [IDW-1:0] id, input int hold);
    logic [63:0] exp_data;
    wait_ready_r();
    ar_valid_i = 1; ar_addr_i = addr; ar_len_i = len; ar_id_i = id;
    tick();
    ar_valid_i = 0;
    exp_data = model_read(addr, len);
    check("r_valid", r_valid_o, 1);
    check("r_data", r_data_o, exp_data);
    check("r_resp", r_resp_o, model_err(addr, len) ? 2'b10 : 2'b00);
    check("r_id", r_id_o, id);
    check("r_last", r_last_o, 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("r_hold_valid", r_valid_o, 1);
      check("r_hold_data", r_data_o, exp_data);
    end
    r_ready_i = 1;
    tick();
    r_ready_i = 0;
    check("r_valid_clear", r_valid_o, 0);
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned sel = $urandom_range(0, 9);
    if (sel == 0) return BASE + 64'(DEPTH * 8) + 64'(8 * $urandom_range(0, 15));
    if (sel == 1) return BASE - 64'(8 * $urandom_range(1, 16));
    return BASE + 64'(8 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [1:0]  resp;
    logic [63:0] old_data;
    logic [31:0] base_cnt;
    logic [63:0] addrs [4];

    model_clear();
    rst_i = 1;
    repeat (3) tick();
    rst_i = 0;
    check("rst_aw_ready", aw_ready_o, 1);
    check("rst_w_ready", w_ready_o, 1);
    check("rst_ar_ready", ar_ready_o, 1);
    check("rst_b_valid", b_valid_o, 0);
    check("rst_r_valid", r_valid_o, 0);
    check("rst_wr_count", wr_count_o, 0);
    check("rst_b_id", b_id_o, 0);
    check("rst_r_data", r_data_o, 0);

    // Simultaneous AW/W, then read-back.
    do_write(64'h9000_0000, 64'hdead_beef_1234_5678, 8'hFF, 0, 10'h12);
    do_read(64'h9000_0000, 0, 10'h21, 0);
    check("t1_count", wr_count_o, 1);

    // W leads AW by 3 cycles.
    drive_w(64'h0123_4567_89ab_cdef, 8'hFF);
    tick();
    w_valid_i = 0;
    check("t2_w_held", w_ready_o, 0);
    check("t2_aw_ready", aw_ready_o, 1);
    tick(); tick();
    check("t2_no_b", b_valid_o, 0);
    drive_aw(64'h9000_0100, 0, 10'h33);
    tick();
    aw_valid_i = 0;
    model_write(64'h9000_0100, 64'h0123_4567_89ab_cdef, 8'hFF, 0, resp);
    check("t2_b_early", b_valid_o, 0);
    tick();
    check("t2_b_valid", b_valid_o, 1);
    check("t2_b_resp", b_resp_o, resp);
    check("t2_b_id", b_id_o, 10'h33);
    b_ready_i = 1; tick(); b_ready_i = 0;
    do_read(64'h9000_0100, 0, 10'h34, 1);

    // Partial strobe over a zero word.
    do_write(64'h9000_0008, '1, 8'h0F, 0, 10'h40);
    do_read(64'h9000_0008, 0, 10'h41, 0);
    check("t3_partial", r_data_o, 64'h0000_0000_FFFF_FFFF);

    // Out-of-range and burst requests.
    base_cnt = model_cnt;
    do_write(64'h9000_0200, '1, 8'hFF, 0, 10'h50);
    do_write(64'h8FFF_FFF8, '1, 8'hFF, 0, 10'h51);
    do_write(64'h9000_0000, '1, 8'hFF, 3, 10'h52);
    check("t4_count", wr_count_o, base_cnt);
    do_read(64'h9000_0200, 0, 10'h53, 0);
    do_read(64'h8FFF_FFF8, 0, 10'h54, 0);
    do_read(64'h9000_0000, 1, 10'h55, 0);
    do_read(64'h9000_01F8, 0, 10'h56, 0);
    do_read(64'h9000_0000, 0, 10'h57, 0);

    // Stalled B with a second write queued behind it.
    base_cnt = model_cnt;
    drive_aw(64'h9000_0040, 0, 10'h05);
    drive_w(64'haaaa_bbbb_cccc_dddd, 8'hFF);
    tick();
    aw_valid_i = 0; w_valid_i = 0;
    model_write(64'h9000_0040, 64'haaaa_bbbb_cccc_dddd, 8'hFF, 0, resp);
    tick();
    check("t5_b1_valid", b_valid_o, 1);
    drive_aw(64'h9000_0048, 0, 10'h06);
    drive_w(64'h1111_2222_3333_4444, 8'hF0);
    tick();
    aw_valid_i = 0; w_valid_i = 0;
    check("t5_aw_held", aw_ready_o, 0);
    check("t5_w_held", w_ready_o, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_b1_stable", b_valid_o, 1);
      check("t5_b1_id", b_id_o, 10'h05);
      check("t5_b1_resp", b_resp_o, 0);
      check("t5_count_blocked", wr_count_o, base_cnt + 1);
    end
    b_ready_i = 1; tick(); b_ready_i = 0;
    check("t5_b_gap", b_valid_o, 0);
    model_write(64'h9000_0048, 64'h1111_2222_3333_4444, 8'hF0, 0, resp);
    tick();
    check("t5_b2_valid", b_valid_o, 1);
    check("t5_b2_id", b_id_o, 10'h06);
    check("t5_count_end", wr_count_o, base_cnt + 2);
    b_ready_i = 1; tick(); b_ready_i = 0;
    do_read(64'h9000_0048, 0, 10'h07, 0);

    // Commit and AR to the same word on the same edge.
    do_write(64'h9000_0080, 64'h5555_5555_5555_5555, 8'hFF, 0, 10'h60);
    old_data = model_read(64'h9000_0080, 0);
    drive_aw(64'h9000_0080, 0, 10'h61);
    drive_w(64'h7777_8888_9999_0000, 8'hFF);
    tick();
    aw_valid_i = 0; w_valid_i = 0;
    ar_valid_i = 1; ar_addr_i = 64'h9000_0080; ar_len_i = 0; ar_id_i = 10'h62;
    tick();
    ar_valid_i = 0;
    check("t6_same_edge_b", b_valid_o, 1);
    check("t6_old_data", r_data_o, old_data);
    model_write(64'h9000_0080, 64'h7777_8888_9999_0000, 8'hFF, 0, resp);
    b_ready_i = 1; r_ready_i = 1; tick(); b_ready_i = 0; r_ready_i = 0;
    do_read(64'h9000_0080, 0, 10'h63, 0);

    // Back-to-back reads with r_ready held high.
    addrs[0] = 64'h9000_0000; addrs[1] = 64'h9000_0100;
    addrs[2] = 64'h9000_0300; addrs[3] = 64'h9000_0080;
    r_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      ar_valid_i = 1; ar_addr_i = addrs[i]; ar_len_i = 0; ar_id_i = IDW'(i);
      tick();
      check("b2b_valid", r_valid_o, 1);
      check("b2b_data", r_data_o, model_read(addrs[i], 0));
      check("b2b_id", r_id_o, i);
    end
    ar_valid_i = 0;
    tick();
    r_ready_i = 0;
    check("b2b_drain", r_valid_o, 0);

    // Reset while B is pending.
    drive_aw(64'h9000_00C0, 0, 10'h70);
    drive_w(64'hFFFF_0000_FFFF_0000, 8'hFF);
    tick();
    aw_valid_i = 0; w_valid_i = 0;
    tick();
    check("t6_b_pending", b_valid_o, 1);
    rst_i = 1; tick(); rst_i = 0;
    model_clear();
    check("t6_rst_b", b_valid_o, 0);
    check("t6_rst_count", wr_count_o, 0);
    check("t6_rst_aw_ready", aw_ready_o, 1);
    do_read(64'h9000_0000, 0, 10'h71, 0);
    do_read(64'h9000_00C0, 0, 10'h72, 0);
    do_read(64'h9000_0100, 0, 10'h73, 0);

    // Randomized single-beat traffic.
    for (int n = 0; n < 200; n++) begin
      logic [63:0] a = rand_addr();
      logic [7:0]  len = ($urandom_range(0, 11) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      if ($urandom_range(0, 1) == 0)
        do_write(a, {$urandom, $urandom}, 8'($urandom), len, IDW'($urandom));
      else
        do_read(a, len, IDW'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
